// File: rtl/multiplier_pkg.sv
// Shared definitions for the multiplier / modular-reduction datapath.
// The divider pieces reuse BLOCK_LENGTH so that widths stay consistent
// with the multiplier that feeds it.
package multiplier_pkg;

    // Width of one operand block; products are 2*BLOCK_LENGTH bits.
    localparam int BLOCK_LENGTH = 16;

    // Divider control states.
    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_CALC,
        DIV_DONE
    } div_state_e;

    // One quotient bit is resolved per iteration, so a full divide takes
    // one iteration per dividend bit.
    localparam int DIV_ITERATIONS = 2 * BLOCK_LENGTH;
    localparam int DIV_CNT_WIDTH  = $clog2(DIV_ITERATIONS);

endpackage

// File: rtl/divider_step.sv
// One radix-2 restoring division step: shift the next dividend bit into
// the partial remainder, trial-subtract the divisor, and keep the
// difference only if it did not go negative.
module divider_step
    import multiplier_pkg::*;
(
    input  logic [BLOCK_LENGTH:0]   part_rem,
    input  logic                    dividend_bit,
    input  logic [BLOCK_LENGTH-1:0] divisor,
    output logic [BLOCK_LENGTH:0]   next_rem,
    output logic                    quotient_bit
);

    logic [BLOCK_LENGTH+1:0] shifted;
    logic [BLOCK_LENGTH:0]   trial;

    // Compare on the full shifted value so no carry is lost; the
    // difference itself only needs BLOCK_LENGTH+1 bits because it is kept
    // only when it is smaller than the shifted value and non-negative.
    always_comb begin
        shifted      = {part_rem, dividend_bit};
        quotient_bit = (shifted >= {2'b00, divisor});
        trial        = shifted[BLOCK_LENGTH:0] - {1'b0, divisor};
        next_rem     = quotient_bit ? trial : shifted[BLOCK_LENGTH:0];
    end

endmodule

// File: rtl/divider_32x16.sv
// Sequential radix-2 restoring divider: 2*BLOCK_LENGTH-bit dividend by
// BLOCK_LENGTH-bit divisor, one quotient bit per clock, valid/ready on
// both sides. A zero divisor finishes immediately with an all-ones
// quotient and the low dividend bits as remainder.
// Optional macro DIVIDER_FAST_PATH_EN: when defined, a dividend smaller
// than the divisor skips the iterations and finishes in one cycle.
module divider_32x16
    import multiplier_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [2*BLOCK_LENGTH-1:0] dividend_i,
    input  logic [BLOCK_LENGTH-1:0]   divisor_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [2*BLOCK_LENGTH-1:0] quotient_o,
    output logic [BLOCK_LENGTH-1:0]   remainder_o,
    output logic                      div_by_zero_o
);

    localparam int DW = 2 * BLOCK_LENGTH;
    localparam logic [DIV_CNT_WIDTH-1:0] LAST_COUNT = DIV_CNT_WIDTH'(DIV_ITERATIONS - 1);

    div_state_e               state;
    logic [DIV_CNT_WIDTH-1:0] count;
    logic [BLOCK_LENGTH:0]    part_rem;
    // Dividend bits leave from the top while quotient bits enter at the
    // bottom, so after the last iteration this register holds the quotient.
    logic [DW-1:0]            dvd_q;
    logic [BLOCK_LENGTH-1:0]  divisor_q;

    logic [BLOCK_LENGTH:0]    step_rem;
    logic                     step_bit;
    logic                     accept;

    assign accept = in_valid_i && in_ready_o;

    divider_step u_step (
        .part_rem     (part_rem),
        .dividend_bit (dvd_q[DW-1]),
        .divisor      (divisor_q),
        .next_rem     (step_rem),
        .quotient_bit (step_bit)
    );

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= DIV_IDLE;
            in_ready_o    <= 1'b1;
            out_valid_o   <= 1'b0;
            quotient_o    <= '0;
            remainder_o   <= '0;
            div_by_zero_o <= 1'b0;
            count         <= '0;
            part_rem      <= '0;
            dvd_q         <= '0;
            divisor_q     <= '0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (accept) begin
                        in_ready_o <= 1'b0;
                        divisor_q  <= divisor_i;
                        dvd_q      <= dividend_i;
                        part_rem   <= '0;
                        count      <= LAST_COUNT;
                        if (divisor_i == '0) begin
                            state         <= DIV_DONE;
                            out_valid_o   <= 1'b1;
                            quotient_o    <= '1;
                            remainder_o   <= dividend_i[BLOCK_LENGTH-1:0];
                            div_by_zero_o <= 1'b1;
                        end
`ifdef DIVIDER_FAST_PATH_EN
                        else if (dividend_i < {{BLOCK_LENGTH{1'b0}}, divisor_i}) begin
                            state       <= DIV_DONE;
                            out_valid_o <= 1'b1;
                            quotient_o  <= '0;
                            remainder_o <= dividend_i[BLOCK_LENGTH-1:0];
                        end
`endif
                        else begin
                            state <= DIV_CALC;
                        end
                    end
                end

                DIV_CALC: begin
                    part_rem <= step_rem;
                    dvd_q    <= {dvd_q[DW-2:0], step_bit};
                    if (count == '0) begin
                        state       <= DIV_DONE;
                        out_valid_o <= 1'b1;
                        quotient_o  <= {dvd_q[DW-2:0], step_bit};
                        remainder_o <= step_rem[BLOCK_LENGTH-1:0];
                    end else begin
                        count <= count - 1'b1;
                    end
                end

                DIV_DONE: begin
                    if (out_ready_i) begin
                        state         <= DIV_IDLE;
                        out_valid_o   <= 1'b0;
                        in_ready_o    <= 1'b1;
                        div_by_zero_o <= 1'b0;
                    end
                end

                default: begin
                    state       <= DIV_IDLE;
                    in_ready_o  <= 1'b1;
                    out_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider_32x16.sv
// Self-checking bench for divider_32x16. Expected results are computed
// from the operands with native arithmetic, queued when an operation is
// accepted and compared when the divider presents its result.
module tb_divider_32x16;
    import multiplier_pkg::*;

`ifdef DIVIDER_FAST_PATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    typedef struct {
        logic [31:0] q;
        logic [15:0] r;
        logic        dbz;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   cycle = 0;
    int   accept_cycle = 0;
    int   errors = 0;
    int   checks = 0;

    divider_32x16 dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .dividend_i    (dividend),
        .divisor_i     (divisor),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .quotient_o    (quotient),
        .remainder_o   (remainder),
        .div_by_zero_o (div_by_zero)
    );

    // Free-running clock and cycle counter used for latency measurement.
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Watchdog so the run always ends even if a wait logic bug slips in.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Offer one operation, wait for it to be accepted and queue the
    // expected result; operands are scrambled afterwards to prove they
    // are latched at the accept edge.
    task automatic applyStimulus(input logic [31:0] dvd, input logic [15:0] dsr);
        exp_t e;
        int   waited = 0;
        while (in_ready !== 1'b1 && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        check("in_ready before accept", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        dividend = dvd;
        divisor  = dsr;
        @(posedge clk); #1;
        accept_cycle = cycle;
        in_valid = 1'b0;
        dividend = $urandom;
        divisor  = 16'($urandom);
        if (dsr == 16'd0) begin
            e.q = 32'hFFFF_FFFF; e.r = dvd[15:0]; e.dbz = 1'b1; e.lat = 0;
        end else begin
            e.q = dvd / {16'd0, dsr};
            e.r = 16'(dvd % {16'd0, dsr});
            e.dbz = 1'b0;
            e.lat = (FAST && dvd < {16'd0, dsr}) ? 0 : 32;
        end
        sb.push_back(e);
    endtask

    // Wait for the result, compare it against the scoreboard head, then
    // optionally hold back-pressure for 'hold' cycles before completing
    // the handshake. Latency is counted in edges after the accept edge;
    // 0 means the result is already valid in the cycle after acceptance.
    task automatic checkOutput(input string tag, input int hold);
        exp_t e;
        int   waited = 0;
        out_ready = (hold == 0);
        while (out_valid !== 1'b1 && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        check({tag, " out_valid"}, {31'b0, out_valid}, 32'd1);
        if (sb.size() == 0) begin
            check({tag, " scoreboard empty"}, 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        check({tag, " latency"}, 32'(cycle - accept_cycle), 32'(e.lat));
        check({tag, " quotient"}, quotient, e.q);
        check({tag, " remainder"}, {16'd0, remainder}, {16'd0, e.r});
        check({tag, " div_by_zero"}, {31'b0, div_by_zero}, {31'b0, e.dbz});
        for (int i = 0; i < hold; i++) begin
            if (i == 3) begin
                in_valid = 1'b1;
                dividend = 32'd99;
                divisor  = 16'd3;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            check({tag, " hold quotient"}, quotient, e.q);
            check({tag, " hold remainder"}, {16'd0, remainder}, {16'd0, e.r});
            check({tag, " hold out_valid"}, {31'b0, out_valid}, 32'd1);
            check({tag, " hold in_ready"}, {31'b0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, " valid dropped"}, {31'b0, out_valid}, 32'd0);
        check({tag, " in_ready back"}, {31'b0, in_ready}, 32'd1);
        check({tag, " div_by_zero cleared"}, {31'b0, div_by_zero}, 32'd0);
        if (hold > 0) begin
            @(posedge clk); #1;
            check({tag, " ignored pulse"}, {31'b0, out_valid}, 32'd0);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        dividend  = '0;
        divisor   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", {31'b0, in_ready}, 32'd1);
        check("reset out_valid", {31'b0, out_valid}, 32'd0);
        check("reset quotient", quotient, 32'd0);
        check("reset remainder", {16'd0, remainder}, 32'd0);
        check("reset div_by_zero", {31'b0, div_by_zero}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] square of 0xFFFF divided back");
        applyStimulus(32'hFFFE_0001, 16'hFFFF);
        checkOutput("ffff_sq", 0);

        $display("[TB] 1000/7 and all-ones/1");
        applyStimulus(32'd1000, 16'd7);
        checkOutput("1000_7", 0);
        applyStimulus(32'hFFFF_FFFF, 16'd1);
        checkOutput("max_div1", 0);

        $display("[TB] zero divisor with back-pressure");
        applyStimulus(32'h1234_5678, 16'd0);
        checkOutput("div0", 10);

        $display("[TB] back-pressure on a normal result");
        applyStimulus(32'h8765_4321, 16'h00FF);
        checkOutput("bp_norm", 10);

        $display("[TB] reset during calculation");
        applyStimulus(32'h89AB_CDEF, 16'h1234);
        repeat (15) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        sb.delete(sb.size() - 1);
        check("midrst out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst in_ready", {31'b0, in_ready}, 32'd1);
        check("midrst quotient", quotient, 32'd0);
        check("midrst remainder", {16'd0, remainder}, 32'd0);
        check("midrst div_by_zero", {31'b0, div_by_zero}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("after reset in_ready", {31'b0, in_ready}, 32'd1);
        applyStimulus(32'd1000, 16'd7);
        checkOutput("post_rst_1000_7", 0);

        $display("[TB] dividend smaller than divisor");
        applyStimulus(32'd5, 16'd9);
        checkOutput("small", 0);

        $display("[TB] random operands");
        for (int i = 0; i < 6; i++) begin
            applyStimulus($urandom, 16'($urandom_range(1, 65535)));
            checkOutput("random", 0);
        end
        applyStimulus(32'h0000_1234, 16'hFFFF);
        checkOutput("small_big_dsr", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
